two_phase_nonoverlap: RTL and testbench

// - Generates the ToF pixel modulation clock pair (CLK_OUT / CLK_OUT_N) from the fast clock CLK_IN.
// - The pair is two-phase and non-overlapping, with a selectable phase lag of 0/90/180/270 deg against a phase-0 reference (REF_OUT, light-source clock).
// - Fully synchronous counter/decode design; sits between the readout timing FSM and the sensor pads.

---
 rtl/tpno_pkg.sv | 25 ++
 rtl/tpno_sync2.sv | 29 ++
 rtl/two_phase_nonoverlap.sv | 115 +++++++++++
 tb/tb_two_phase_nonoverlap.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tpno_pkg.sv
// tpno_pkg
// Shared types and helpers for the two-phase non-overlapping modulation clock
// generator (two_phase_nonoverlap).
//   phase_e       : phase lag index applied to CLK_OUT / CLK_OUT_N
//   phase_offset  : counter offset, in CLK_IN cycles, for a given phase index
//   DEFAULT_DIV   : default CLK_IN cycles per quarter modulation period
//   DEFAULT_DEAD  : default dead (both-low) cycles per half period
package tpno_pkg;

  typedef enum logic [1:0] {
    PH0   = 2'd0,
    PH90  = 2'd1,
    PH180 = 2'd2,
    PH270 = 2'd3
  } phase_e;

  localparam int DEFAULT_DIV  = 2;
  localparam int DEFAULT_DEAD = 1;

  // One quarter period is div cycles, so the lag is sel quarters.
  function automatic int phase_offset(input phase_e sel, input int div);
    return int'(sel) * div;
  endfunction

endpackage

// File: rtl/tpno_sync2.sv
// tpno_sync2
// Two-flop synchronizer bank for quasi-static control inputs.
// Ports:
//   CLK_IN   in  1      destination clock
//   RESET_N  in  1      asynchronous active-low reset, clears both stages
//   d        in  WIDTH  asynchronous inputs
//   q        out WIDTH  synchronized outputs (2 cycles latency)
module tpno_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             CLK_IN,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/two_phase_nonoverlap.sv
// two_phase_nonoverlap
// ToF pixel modulation clock pair generator. A free-running counter over one
// modulation period (P = 4*DIV CLK_IN cycles) is decoded into a phase-0
// reference (REF_OUT) and a two-phase non-overlapping pair (CLK_OUT /
// CLK_OUT_N) lagged by 0/90/180/270 degrees.
// Ports:
//   CLK_IN      in  1  fast clock, rising edge
//   RESET_N     in  1  asynchronous active-low reset
//   DRAIN_B     in  1  modulation enable; 0 holds CLK_OUT/CLK_OUT_N low
//   PHASE_SEL1  in  1  phase select LSB
//   PHASE_SEL2  in  1  phase select MSB
//   CLK_OUT     out 1  lagged modulation clock
//   CLK_OUT_N   out 1  non-overlapping complement of CLK_OUT
//   REF_OUT     out 1  phase-0 reference, 50% duty, never gated
//   SEL_ACTIVE  out 2  phase index currently applied
// Build option:
//   TPNO_SEL_SYNC_EN  when defined, DRAIN_B and PHASE_SEL1/2 are passed
//                     through a 2-flop synchronizer before use.
module two_phase_nonoverlap
  import tpno_pkg::*;
#(
  parameter int DIV      = DEFAULT_DIV,
  parameter int DEAD_CYC = DEFAULT_DEAD
) (
  input  logic       CLK_IN,
  input  logic       RESET_N,
  input  logic       DRAIN_B,
  input  logic       PHASE_SEL1,
  input  logic       PHASE_SEL2,
  output logic       CLK_OUT,
  output logic       CLK_OUT_N,
  output logic       REF_OUT,
  output logic [1:0] SEL_ACTIVE
);

  localparam int P  = 4 * DIV;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  if (DIV < 1) begin : g_div_check
    $error("two_phase_nonoverlap: DIV must be >= 1");
  end

  if ((DEAD_CYC < 0) || (DEAD_CYC >= 2 * DIV)) begin : g_dead_check
    $error("two_phase_nonoverlap: DEAD_CYC must be in [0, 2*DIV)");
  end

  logic       drain_b_eff;
  logic [1:0] sel_eff;

`ifdef TPNO_SEL_SYNC_EN
  logic [2:0] sync_q;

  tpno_sync2 #(
    .WIDTH (3)
  ) u_sync (
    .CLK_IN  (CLK_IN),
    .RESET_N (RESET_N),
    .d       ({DRAIN_B, PHASE_SEL2, PHASE_SEL1}),
    .q       (sync_q)
  );

  assign drain_b_eff = sync_q[2];
  assign sel_eff     = sync_q[1:0];
`else
  assign drain_b_eff = DRAIN_B;
  assign sel_eff     = {PHASE_SEL2, PHASE_SEL1};
`endif

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  phase_e        sel_active_q;
  phase_e        sel_active_nxt;
  logic          wrap;
  int            s_nxt;
  logic          ref_nxt;
  logic          clk_out_nxt;
  logic          clk_out_n_nxt;

  // The phase is only swapped at the period boundary, so a new selection
  // never produces a runt edge in the middle of a pulse.
  always_comb begin : next_state
    wrap           = (cnt_q == CW'(P - 1));
    cnt_nxt        = wrap ? '0 : cnt_q + CW'(1);
    sel_active_nxt = wrap ? phase_e'(sel_eff) : sel_active_q;
  end

  // Decoding the next-state count lets the registered outputs line up with
  // the counter value they share a cycle with. Both pair outputs come from
  // one shifted count, which makes them mutually exclusive by construction.
  always_comb begin : output_decode
    s_nxt         = (int'(cnt_nxt) + P - phase_offset(sel_active_nxt, DIV)) % P;
    ref_nxt       = (int'(cnt_nxt) < 2 * DIV);
    clk_out_nxt   = drain_b_eff && (s_nxt >= DEAD_CYC) && (s_nxt < 2 * DIV);
    clk_out_n_nxt = drain_b_eff && (s_nxt >= 2 * DIV + DEAD_CYC);
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin : state_reg
    if (!RESET_N) begin
      cnt_q        <= '0;
      sel_active_q <= PH0;
      REF_OUT      <= 1'b0;
      CLK_OUT      <= 1'b0;
      CLK_OUT_N    <= 1'b0;
    end else begin
      cnt_q        <= cnt_nxt;
      sel_active_q <= sel_active_nxt;
      REF_OUT      <= ref_nxt;
      CLK_OUT      <= clk_out_nxt;
      CLK_OUT_N    <= clk_out_n_nxt;
    end
  end

  assign SEL_ACTIVE = sel_active_q;

endmodule

// File: tb/tb_two_phase_nonoverlap.sv
// tb_two_phase_nonoverlap
// Bench for two_phase_nonoverlap at DIV=2, DEAD_CYC=1 (P=8), sync option off.
// Expected waveforms per phase are hand-written 8-bit masks indexed by cnt.
module tb_two_phase_nonoverlap;

  logic       CLK_IN     = 1'b0;
  logic       RESET_N    = 1'b0;
  logic       DRAIN_B    = 1'b0;
  logic       PHASE_SEL1 = 1'b0;
  logic       PHASE_SEL2 = 1'b0;
  logic       CLK_OUT;
  logic       CLK_OUT_N;
  logic       REF_OUT;
  logic [1:0] SEL_ACTIVE;

  two_phase_nonoverlap #(
    .DIV      (2),
    .DEAD_CYC (1)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RESET_N    (RESET_N),
    .DRAIN_B    (DRAIN_B),
    .PHASE_SEL1 (PHASE_SEL1),
    .PHASE_SEL2 (PHASE_SEL2),
    .CLK_OUT    (CLK_OUT),
    .CLK_OUT_N  (CLK_OUT_N),
    .REF_OUT    (REF_OUT),
    .SEL_ACTIVE (SEL_ACTIVE)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] out_mask;
    logic [7:0] outn_mask;
  } vec_t;

  typedef struct {
    int         cnt;
    logic [1:0] sel;
    logic       clk_out;
    logic       clk_out_n;
    logic       ref_out;
  } exp_t;

  vec_t       vecs[4];
  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_cnt;
  logic [1:0] m_sel;
  logic [7:0] ref_mask;
  logic [1:0] prev_sel;
  bit         prev_valid;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the state after the next rising edge.
  task automatic cycle(input logic [1:0] sel, input logic drain);
    exp_t       e;
    int         nc;
    logic [1:0] ns;
    logic [7:0] om;
    logic [7:0] nm;
    PHASE_SEL1 = sel[0];
    PHASE_SEL2 = sel[1];
    DRAIN_B    = drain;
    nc = (m_cnt == 7) ? 0 : m_cnt + 1;
    ns = (m_cnt == 7) ? sel : m_sel;
    om = vecs[ns].out_mask;
    nm = vecs[ns].outn_mask;
    e.cnt       = nc;
    e.sel       = ns;
    e.clk_out   = drain & om[nc];
    e.clk_out_n = drain & nm[nc];
    e.ref_out   = ref_mask[nc];
    sb_q.push_back(e);
    m_cnt = nc;
    m_sel = ns;
    @(negedge CLK_IN);
  endtask

  always @(posedge CLK_IN) begin : monitor
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check1("clk_out",   CLK_OUT,    e.clk_out);
      check1("clk_out_n", CLK_OUT_N,  e.clk_out_n);
      check1("ref_out",   REF_OUT,    e.ref_out);
      check1("sel_active", SEL_ACTIVE, e.sel);
      check1("non_overlap", CLK_OUT & CLK_OUT_N, 0);
      if (prev_valid)
        check1("sel_change_at_wrap", (SEL_ACTIVE != prev_sel) && (e.cnt != 0), 0);
      prev_sel   = SEL_ACTIVE;
      prev_valid = 1'b1;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vecs[0] = '{2'd0, 8'b0000_1110, 8'b1110_0000};
    vecs[1] = '{2'd1, 8'b0011_1000, 8'b1000_0011};
    vecs[2] = '{2'd2, 8'b1110_0000, 8'b0000_1110};
    vecs[3] = '{2'd3, 8'b1000_0011, 8'b0011_1000};
    ref_mask   = 8'b0000_1111;
    m_cnt      = 0;
    m_sel      = 2'd0;
    prev_valid = 1'b0;

    RESET_N = 1'b0;
    repeat (2) @(negedge CLK_IN);
    check1("rst_clk_out",    CLK_OUT,    0);
    check1("rst_clk_out_n",  CLK_OUT_N,  0);
    check1("rst_ref_out",    REF_OUT,    0);
    check1("rst_sel_active", SEL_ACTIVE, 0);
    RESET_N = 1'b1;

    // Phase 0 run
    repeat (16) cycle(2'd0, 1'b1);

    // sel=01 applied mid-period at cnt 3; must hold 0 until the wrap
    while (m_cnt != 3) cycle(2'd0, 1'b1);
    cycle(2'd1, 1'b1);
    check1("sel_hold_mid_period", SEL_ACTIVE, 0);
    repeat (20) cycle(2'd1, 1'b1);

    // sel=11
    repeat (16) cycle(2'd3, 1'b1);

    // Table sweep over all phases
    for (int i = 0; i < 4; i++)
      repeat (16) cycle(vecs[i].sel, 1'b1);

    // Drain gating for 20 cycles, then re-enable
    repeat (3) cycle(2'd1, 1'b1);
    repeat (20) cycle(2'd1, 1'b0);
    repeat (16) cycle(2'd1, 1'b1);

    // Asynchronous reset mid-period with outputs active
    for (int k = 0; k < 40 && !(m_cnt == 0 && m_sel == 2'd3); k++)
      cycle(2'd3, 1'b1);
    check1("pre_rst_clk_out", CLK_OUT, 1);
    check1("pre_rst_ref_out", REF_OUT, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check1("async_rst_clk_out",    CLK_OUT,    0);
    check1("async_rst_clk_out_n",  CLK_OUT_N,  0);
    check1("async_rst_ref_out",    REF_OUT,    0);
    check1("async_rst_sel_active", SEL_ACTIVE, 0);
    prev_valid = 1'b0;
    m_cnt      = 0;
    m_sel      = 2'd0;
    repeat (2) @(negedge CLK_IN);
    RESET_N = 1'b1;
    repeat (16) cycle(2'd0, 1'b1);

    // Random phase and drain
    repeat (10000)
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0));

    repeat (2) @(negedge CLK_IN);
    check1("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
